// File: rtl/iic_pkg.sv
// iic_pkg: shared definitions for the IicMaster register-access sequencer.
//   - IicMaster 10-bit command word encodings and builder functions
//   - sequencer state enumeration
//   - latched request record
package iic_pkg;

   // Bus-condition command words.
   localparam logic [9:0] IIC_CMD_START = 10'b1_0000_0000_0;
   localparam logic [9:0] IIC_CMD_STOP  = 10'b1_1000_0000_0;

   // In a read, result index 0..2 are the transmitted slave-address (write),
   // register-address and slave-address (read) bytes; data starts at 3.
   localparam int IIC_RD_DATA_IDX = 3;

   // Transmit one byte; the ack slot is released so the slave can drive it.
   function automatic logic [9:0] iic_cmd_tx(input logic [7:0] b);
      return {1'b0, b, 1'b1};
   endfunction

   // Receive one byte: SDA released for the data bits, master drives ack
   // (0 = ACK, 1 = NAK for the final byte).
   function automatic logic [9:0] iic_cmd_rx(input logic nak);
      return {1'b0, 8'hFF, nak};
   endfunction

   typedef enum logic [3:0] {
      S_IDLE,
      S_ST,     // start
      S_SAW,    // slave address, write direction
      S_RA,     // register address
      S_WD,     // write data bytes
      S_RST,    // repeated start
      S_SAR,    // slave address, read direction
      S_RDB,    // read data bytes
      S_SP,     // stop
      S_WAIT,   // drain remaining results
      S_FIN     // completion pulse
   } state_e;

   typedef struct packed {
      logic       rd;
      logic [6:0] sa;
      logic [7:0] ra;
   } iic_req_t;

endpackage

// File: rtl/iic_rsp_tracker.sv
// iic_rsp_tracker: follows the 9-bit result words returned by IicMaster.
//   clk, rst       clock, async active-high reset
//   clear          start of a new request: zero the counter and NAK flag
//   active         results are only counted while a request is in flight
//   rd             current request is a read
//   exp_cnt        number of result words the request will produce
//   rsp_din/valid  result word from the master ([8:1] byte, [0] ack bit)
//   rsp_all_done   all expected results have arrived
//   nak_acc        sticky: a master-transmitted byte was NAKed
//   rd_data/valid  read data byte, one-cycle strobe one cycle after rsp_valid
module iic_rsp_tracker
   import iic_pkg::*;
#(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             active,
   input  logic             rd,
   input  logic [CNT_W-1:0] exp_cnt,
   input  logic [8:0]       rsp_din,
   input  logic             rsp_valid,
   output logic             rsp_all_done,
   output logic             nak_acc,
   output logic [7:0]       rd_data,
   output logic             rd_valid
);

   logic [CNT_W-1:0] rsp_idx;

   assign rsp_all_done = (rsp_idx == exp_cnt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_idx  <= '0;
         nak_acc  <= 1'b0;
         rd_data  <= 8'h00;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         if (clear) begin
            rsp_idx <= '0;
            nak_acc <= 1'b0;
         end else if (active && rsp_valid && !rsp_all_done) begin
            rsp_idx <= rsp_idx + CNT_W'(1);
            if (rd && (rsp_idx >= CNT_W'(IIC_RD_DATA_IDX))) begin
               rd_valid <= 1'b1;
               rd_data  <= rsp_din[8:1];
            end else if (rsp_din[0]) begin
               // Ack bit high on a byte the master transmitted: slave NAK.
               nak_acc <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/iic_reg_ctrl.sv
// iic_reg_ctrl: register-level request sequencer in front of the IicMaster
// command and result FIFOs. One request (slave address, register address,
// direction, byte count) is expanded into START / address / [repeated START /
// address] / data / STOP command words; results are drained and a single
// done pulse with nak/tmo status is reported.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_rd/sa/ra/len         request fields, latched on accept
//   wd_data/wd_valid/wd_ready  write data; wd_ready marks the byte consumed
//   rd_data/rd_valid         read data strobe, no backpressure
//   done/nak/tmo             completion pulse; nak/tmo held until next accept
//   cmd_din/cmd_write/cmd_full command FIFO write side
//   rsp_din/rsp_valid        result words from the master
//
// Handshake: a request transfers on a cycle where req_valid && req_ready; a
// command word transfers on a cycle where cmd_write is high (only issued when
// cmd_full is low); a write byte transfers on a cycle where wd_ready is high.
//
// Build option: define IIC_TIMEOUT_EN to add a no-progress watchdog of
// TIMEOUT cycles that forces completion with tmo=1.
module iic_reg_ctrl
   import iic_pkg::*;
#(
   parameter int LEN_W   = 4,
   parameter int TIMEOUT = 100000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_rd,
   input  logic [6:0]       req_sa,
   input  logic [7:0]       req_ra,
   input  logic [LEN_W-1:0] req_len,
   input  logic [7:0]       wd_data,
   input  logic             wd_valid,
   output logic             wd_ready,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   output logic             done,
   output logic             nak,
   output logic             tmo,
   output logic [9:0]       cmd_din,
   output logic             cmd_write,
   input  logic             cmd_full,
   input  logic [8:0]       rsp_din,
   input  logic             rsp_valid
);

   // Wide enough for len + 3 results.
   localparam int CNT_W = LEN_W + 2;

   state_e           state;
   iic_req_t         req;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] byte_cnt;
   logic [CNT_W-1:0] exp_cnt;

   logic             accept;
   logic             active;
   logic             last_byte;
   logic             rsp_all_done;
   logic             nak_acc;
   logic             tmo_hit;
   logic [LEN_W-1:0] len_eff;

   assign req_ready = (state == S_IDLE);
   assign accept    = req_valid && req_ready;
   assign active    = (state != S_IDLE) && (state != S_FIN);
   assign last_byte = (byte_cnt == len - LEN_W'(1));

   // A zero-length read still fetches one byte.
   assign len_eff = (req_rd && (req_len == '0)) ? LEN_W'(1) : req_len;

   // Command issue is combinational so cmd_write reacts to cmd_full in the
   // same cycle; the FIFO never sees a write while it reports full.
   always_comb begin
      cmd_write = 1'b0;
      cmd_din   = '0;
      wd_ready  = 1'b0;
      case (state)
         S_ST, S_RST: if (!cmd_full) begin
            cmd_write = 1'b1;
            cmd_din   = IIC_CMD_START;
         end
         S_SAW: if (!cmd_full) begin
            cmd_write = 1'b1;
            cmd_din   = iic_cmd_tx({req.sa, 1'b0});
         end
         S_RA: if (!cmd_full) begin
            cmd_write = 1'b1;
            cmd_din   = iic_cmd_tx(req.ra);
         end
         S_WD: if (wd_valid && !cmd_full) begin
            cmd_write = 1'b1;
            wd_ready  = 1'b1;
            cmd_din   = iic_cmd_tx(wd_data);
         end
         S_SAR: if (!cmd_full) begin
            cmd_write = 1'b1;
            cmd_din   = iic_cmd_tx({req.sa, 1'b1});
         end
         S_RDB: if (!cmd_full) begin
            cmd_write = 1'b1;
            cmd_din   = iic_cmd_rx(last_byte);
         end
         S_SP: if (!cmd_full) begin
            cmd_write = 1'b1;
            cmd_din   = IIC_CMD_STOP;
         end
         default: ;
      endcase
   end

`ifdef IIC_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] wdog;

   // Counts cycles of no progress; any command issued or result received
   // counts as progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog <= '0;
      end else if (!active || rsp_valid || cmd_write) begin
         wdog <= '0;
      end else if (!tmo_hit) begin
         wdog <= wdog + WD_W'(1);
      end
   end

   assign tmo_hit = active && (wdog == WD_W'(TIMEOUT - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         req      <= '0;
         len      <= '0;
         byte_cnt <= '0;
         exp_cnt  <= '0;
         done     <= 1'b0;
         nak      <= 1'b0;
         tmo      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: if (accept) begin
               req.rd   <= req_rd;
               req.sa   <= req_sa;
               req.ra   <= req_ra;
               len      <= len_eff;
               byte_cnt <= '0;
               exp_cnt  <= CNT_W'(len_eff) + (req_rd ? CNT_W'(3) : CNT_W'(2));
               nak      <= 1'b0;
               tmo      <= 1'b0;
               state    <= S_ST;
            end
            S_ST:  if (cmd_write) state <= S_SAW;
            S_SAW: if (cmd_write) state <= S_RA;
            S_RA: if (cmd_write) begin
               if (req.rd)          state <= S_RST;
               else if (len == '0)  state <= S_SP;
               else                 state <= S_WD;
            end
            S_WD, S_RDB: if (cmd_write) begin
               byte_cnt <= byte_cnt + LEN_W'(1);
               if (last_byte) state <= S_SP;
            end
            S_RST: if (cmd_write) state <= S_SAR;
            S_SAR: if (cmd_write) state <= S_RDB;
            S_SP:  if (cmd_write) state <= S_WAIT;
            S_WAIT: if (rsp_all_done) begin
               state <= S_FIN;
               done  <= 1'b1;
               nak   <= nak_acc;
            end
            S_FIN: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
         // Watchdog overrides whatever the sequence was doing.
         if (tmo_hit) begin
            state <= S_FIN;
            done  <= 1'b1;
            nak   <= nak_acc;
            tmo   <= 1'b1;
         end
      end
   end

   iic_rsp_tracker #(
      .CNT_W(CNT_W)
   ) u_rsp_tracker (
      .clk          (clk),
      .rst          (rst),
      .clear        (accept),
      .active       (active),
      .rd           (req.rd),
      .exp_cnt      (exp_cnt),
      .rsp_din      (rsp_din),
      .rsp_valid    (rsp_valid),
      .rsp_all_done (rsp_all_done),
      .nak_acc      (nak_acc),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid)
   );

endmodule

// File: tb/tb_iic_reg_ctrl.sv
// tb_iic_reg_ctrl: bench for iic_reg_ctrl. An I2C bus/slave model at address
// 0x5a (256-byte RAM) answers the command words; expected command streams,
// read data and status come from a request-level reference RAM.
module tb_iic_reg_ctrl;

   localparam int         LEN_W = 4;
   localparam int         TMO   = 1000;
   localparam logic [6:0] SLV   = 7'h5a;
   localparam logic [9:0] C_START = 10'h200;
   localparam logic [9:0] C_STOP  = 10'h300;
   localparam int P_IDLE = 0, P_ADDR = 1, P_PTR = 2, P_WDATA = 3, P_RDATA = 4, P_NONE = 5;

   logic             clk, rst;
   logic             req_valid, req_ready, req_rd;
   logic [6:0]       req_sa;
   logic [7:0]       req_ra;
   logic [LEN_W-1:0] req_len;
   logic [7:0]       wd_data;
   logic             wd_valid, wd_ready;
   logic [7:0]       rd_data;
   logic             rd_valid, done, nak, tmo;
   logic [9:0]       cmd_din;
   logic             cmd_write, cmd_full;
   logic [8:0]       rsp_din;
   logic             rsp_valid;

   iic_reg_ctrl #(.LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_rd(req_rd), .req_sa(req_sa), .req_ra(req_ra), .req_len(req_len),
      .wd_data(wd_data), .wd_valid(wd_valid), .wd_ready(wd_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .nak(nak), .tmo(tmo),
      .cmd_din(cmd_din), .cmd_write(cmd_write), .cmd_full(cmd_full),
      .rsp_din(rsp_din), .rsp_valid(rsp_valid)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- environment state ----------------
   int vectors = 0, miscompares = 0;
   logic [9:0] exp_cmd_q[$];
   logic [7:0] exp_rd_q[$];
   logic [7:0] wd_src_q[$];
   logic [7:0] fix_q[$];
   logic [8:0] rsp_q[$];
   logic [7:0] slv_mem[256];
   logic [7:0] ref_mem[256];
   int   slv_phase = P_IDLE;
   logic [7:0] slv_ptr = 8'h00;
   int   cmd_cnt = 0, wd_cnt = 0, rd_cnt = 0, cyc = 0;
   int   full_hold = 0, wd_gap = 0, hold_at = -1;
   int   last_cmd_cyc = 0, done_cyc = 0;
   bit   rnd_full = 0, bus_stuck = 0, wd_take = 0, done_seen = 0;
   logic done_nak = 1'b0, done_tmo = 1'b0;
   int   n_cmd_exp = 0, n_rd_exp = 0, n_wd_exp = 0;
   logic nak_exp = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bus + slave: a byte slot is a wired-AND of what the master and the
   // slave drive; the ack slot likewise.
   task automatic bus_cmd(input logic [9:0] w);
      logic [7:0] b;
      logic       a;
      if (w == C_START) begin
         slv_phase = P_ADDR;
      end else if (w == C_STOP) begin
         slv_phase = P_IDLE;
      end else begin
         b = w[8:1];
         a = w[0];
         case (slv_phase)
            P_ADDR: begin
               if (b[7:1] == SLV) begin
                  a = 1'b0;
                  slv_phase = b[0] ? P_RDATA : P_PTR;
               end else begin
                  slv_phase = P_NONE;
               end
            end
            P_PTR: begin
               slv_ptr = b; a = 1'b0; slv_phase = P_WDATA;
            end
            P_WDATA: begin
               slv_mem[slv_ptr] = b; slv_ptr = slv_ptr + 8'd1; a = 1'b0;
            end
            P_RDATA: begin
               b = b & slv_mem[slv_ptr]; slv_ptr = slv_ptr + 8'd1;
            end
            default: ;
         endcase
         rsp_q.push_back({b, a});
      end
   endtask

   // Monitor: samples DUT outputs on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            if (cmd_write) begin
               cmd_cnt++;
               last_cmd_cyc = cyc;
               if (exp_cmd_q.size() == 0) chk("cmd_extra", 32'(cmd_din), 32'h0);
               else chk("cmd_word", 32'(cmd_din), 32'(exp_cmd_q.pop_front()));
               bus_cmd(cmd_din);
               if (cmd_cnt == hold_at) full_hold = 50;
            end
            if (wd_ready) begin
               wd_take = 1;
               wd_cnt++;
            end
            if (rd_valid) begin
               rd_cnt++;
               if (exp_rd_q.size() > 0) chk("rd_data", 32'(rd_data), 32'(exp_rd_q.pop_front()));
            end
            if (done) begin
               done_seen = 1;
               done_nak  = nak;
               done_tmo  = tmo;
               done_cyc  = cyc;
            end
         end
      end
   end

   // Responder: drives write data, FIFO-full and result words after the edge.
   initial begin
      wd_valid = 1'b0; wd_data = 8'h00; cmd_full = 1'b0;
      rsp_valid = 1'b0; rsp_din = 9'h000;
      forever begin
         @(posedge clk);
         #1;
         if (wd_take) begin
            if (wd_src_q.size() > 0) wd_src_q.delete(0);
            wd_take = 0;
         end
         if (wd_gap > 0) begin
            wd_gap--;
            wd_valid = 1'b0;
         end else begin
            wd_valid = (wd_src_q.size() > 0) && ($urandom_range(0, 3) != 0);
         end
         wd_data = (wd_src_q.size() > 0) ? wd_src_q[0] : 8'h00;
         if (full_hold > 0) begin
            cmd_full = 1'b1;
            full_hold--;
         end else begin
            cmd_full = rnd_full && ($urandom_range(0, 3) == 0);
         end
         rsp_valid = 1'b0;
         if (!bus_stuck && rsp_q.size() > 0 && $urandom_range(0, 2) != 0) begin
            rsp_din   = rsp_q.pop_front();
            rsp_valid = 1'b1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic plan_req(input bit rd, input logic [6:0] sa, input logic [7:0] ra,
                           input logic [3:0] len, input int hold, input int gap);
      int leff;
      logic [7:0] d, a;
      leff = (rd && len == 0) ? 1 : int'(len);
      cmd_cnt = 0; wd_cnt = 0; rd_cnt = 0; done_seen = 0;
      hold_at = hold; wd_gap = gap;
      exp_cmd_q.push_back(C_START);
      exp_cmd_q.push_back({1'b0, sa, 1'b0, 1'b1});
      exp_cmd_q.push_back({1'b0, ra, 1'b1});
      if (rd) begin
         exp_cmd_q.push_back(C_START);
         exp_cmd_q.push_back({1'b0, sa, 1'b1, 1'b1});
         for (int i = 0; i < leff; i++) begin
            a = ra + 8'(i);
            exp_cmd_q.push_back({1'b0, 8'hFF, (i == leff - 1)});
            exp_rd_q.push_back((sa == SLV) ? ref_mem[a] : 8'hFF);
         end
      end else begin
         for (int i = 0; i < leff; i++) begin
            a = ra + 8'(i);
            d = (fix_q.size() > 0) ? fix_q.pop_front() : 8'($urandom);
            wd_src_q.push_back(d);
            exp_cmd_q.push_back({1'b0, d, 1'b1});
            if (sa == SLV) ref_mem[a] = d;
         end
      end
      exp_cmd_q.push_back(C_STOP);
      n_cmd_exp = exp_cmd_q.size();
      n_rd_exp  = rd ? leff : 0;
      n_wd_exp  = rd ? 0 : leff;
      nak_exp   = (sa != SLV);
   endtask

   task automatic issue_req(input bit rd, input logic [6:0] sa, input logic [7:0] ra,
                            input logic [3:0] len);
      @(posedge clk);
      #1;
      req_rd = rd; req_sa = sa; req_ra = ra; req_len = len; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_rd = 1'($urandom); req_sa = 7'($urandom); req_ra = 8'($urandom);
      req_len = 4'($urandom);
   endtask

   task automatic wait_done(input int budget);
      int w;
      w = 0;
      while (!done_seen && w < budget) begin
         @(negedge clk);
         #1;
         w++;
      end
   endtask

   task automatic run_req(input string tag, input bit rd, input logic [6:0] sa,
                          input logic [7:0] ra, input logic [3:0] len,
                          input int hold, input int gap);
      @(negedge clk);
      chk({tag, "_ready"}, 32'(req_ready), 32'h1);
      plan_req(rd, sa, ra, len, hold, gap);
      issue_req(rd, sa, ra, len);
      wait_done(3000);
      chk({tag, "_done"}, 32'(done_seen), 32'h1);
      chk({tag, "_nak"}, 32'(done_nak), 32'(nak_exp));
      chk({tag, "_tmo"}, 32'(done_tmo), 32'h0);
      chk({tag, "_ncmd"}, 32'(cmd_cnt), 32'(n_cmd_exp));
      chk({tag, "_nwd"}, 32'(wd_cnt), 32'(n_wd_exp));
      chk({tag, "_nrd"}, 32'(rd_cnt), 32'(n_rd_exp));
      @(negedge clk);
      chk({tag, "_ready_back"}, 32'(req_ready), 32'h1);
      chk({tag, "_done_pulse"}, 32'(done), 32'h0);
      chk({tag, "_nak_held"}, 32'(nak), 32'(nak_exp));
      exp_cmd_q.delete(); exp_rd_q.delete(); wd_src_q.delete(); fix_q.delete();
      hold_at = -1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'h1);
      chk({tag, "_cmd_write"}, 32'(cmd_write), 32'h0);
      chk({tag, "_cmd_din"},   32'(cmd_din),   32'h0);
      chk({tag, "_wd_ready"},  32'(wd_ready),  32'h0);
      chk({tag, "_rd_valid"},  32'(rd_valid),  32'h0);
      chk({tag, "_rd_data"},   32'(rd_data),   32'h0);
      chk({tag, "_done"},      32'(done),      32'h0);
      chk({tag, "_nak"},       32'(nak),       32'h0);
      chk({tag, "_tmo"},       32'(tmo),       32'h0);
   endtask

   // Reset the DUT and everything the real FIFOs/master would lose.
   task automatic reset_env(input string tag);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals(tag);
      exp_cmd_q.delete(); exp_rd_q.delete(); rsp_q.delete(); wd_src_q.delete();
      fix_q.delete();
      slv_phase = P_IDLE; full_hold = 0; wd_take = 0; hold_at = -1; bus_stuck = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Hang guard.
   initial begin
      #600000;
      $display("FAIL global_timeout vectors=%0d", vectors);
      $fatal(1, "bench hang");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [6:0] sa;
      int w;
      rst = 1'b1; req_valid = 1'b0; req_rd = 1'b0; req_sa = '0; req_ra = '0; req_len = '0;
      for (int i = 0; i < 256; i++) begin
         slv_mem[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Absent slave: every transmitted byte NAKed.
      fix_q.push_back(8'h39);
      run_req("wr_absent", 1'b0, 7'h5b, 8'h39, 4'd1, -1, 0);
      // Burst write then read-back past the written bytes.
      fix_q.push_back(8'hC9); fix_q.push_back(8'h65);
      run_req("wr_burst", 1'b0, SLV, 8'h39, 4'd2, -1, 0);
      chk("ram_39", 32'(slv_mem[8'h39]), 32'hC9);
      chk("ram_3a", 32'(slv_mem[8'h3A]), 32'h65);
      run_req("rd_back", 1'b1, SLV, 8'h39, 4'd3, -1, 0);
      // Command FIFO full for 50 cycles mid-request, write data late.
      fix_q.push_back(8'hC9); fix_q.push_back(8'h65);
      run_req("wr_bp", 1'b0, SLV, 8'h39, 4'd2, 3, 20);
      run_req("rd_bp", 1'b1, SLV, 8'h39, 4'd3, 4, 0);
      // Zero-length write and zero-length read (executed as one byte).
      run_req("wr_len0", 1'b0, SLV, 8'h80, 4'd0, -1, 0);
      run_req("rd_len0", 1'b1, SLV, 8'h39, 4'd0, -1, 0);
      run_req("rd_absent", 1'b1, 7'h11, 8'h39, 4'd2, -1, 0);
      // A stray NAK result while idle must not be counted.
      rsp_q.push_back(9'h1FF);
      repeat (6) @(posedge clk);
      run_req("wr_after_stray", 1'b0, SLV, 8'h50, 4'd3, -1, 0);

      // Reset after the fourth command word of a read.
      plan_req(1'b1, SLV, 8'h39, 4'd4, -1, 0);
      issue_req(1'b1, SLV, 8'h39, 4'd4);
      w = 0;
      while (cmd_cnt < 4 && w < 300) begin
         @(negedge clk);
         #1;
         w++;
      end
      chk("rst_mid_reached", 32'(cmd_cnt), 32'd4);
      reset_env("rst_mid");
      run_req("wr_after_rst", 1'b0, SLV, 8'h60, 4'd2, -1, 0);

      // Randomized requests with random FIFO-full and data gaps.
      rnd_full = 1;
      for (int n = 0; n < 30; n++) begin
         sa = ($urandom_range(0, 9) < 7) ? SLV : (7'($urandom) ^ SLV ^ 7'h01);
         if (sa == SLV && n % 5 == 4) sa = 7'h22;
         run_req("rand", 1'($urandom), sa, 8'($urandom_range(8'h30, 8'h4f)),
                 4'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1,
                 int'($urandom_range(0, 4)));
      end
      rnd_full = 0;

      // Bus stuck: no result words ever come back.
      @(negedge clk);
      bus_stuck = 1;
      plan_req(1'b0, SLV, 8'h70, 4'd1, -1, 0);
      issue_req(1'b0, SLV, 8'h70, 4'd1);
`ifdef IIC_TIMEOUT_EN
      wait_done(TMO + 300);
      chk("stuck_done", 32'(done_seen), 32'h1);
      chk("stuck_tmo", 32'(done_tmo), 32'h1);
      chk("stuck_delay_ok", 32'((done_cyc - last_cmd_cyc >= TMO - 2) &&
                                (done_cyc - last_cmd_cyc <= TMO + 2)), 32'h1);
`else
      repeat (5000) @(negedge clk);
      #1;
      chk("stuck_busy", 32'(req_ready), 32'h0);
      chk("stuck_no_done", 32'(done_seen), 32'h0);
`endif
      chk("stuck_ncmd", 32'(cmd_cnt), 32'(n_cmd_exp));
      reset_env("stuck_rst");
      run_req("wr_recover", 1'b0, SLV, 8'h71, 4'd2, -1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/iic_reg_ctrl.md
Name: iic_reg_ctrl

Overview:
- Register-access sequencer in front of the IicMaster command and result FIFOs.
- Accepts one register-level request at a time: slave address, register address, direction and byte count. Expands it into IicMaster 10-bit command words (start, address bytes, repeated start, data bytes, stop).
- Consumes the 9-bit per-byte results, returns read bytes and reports a single completion status.
- Lets firmware or other blocks do bulk register writes and reads without hand-building command words.

Parameters:
- LEN_W, 4, width of req_len; max burst is 2**LEN_W-1 bytes.
- TIMEOUT, 100000, cycles without a result word before abort (used only with IIC_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request strobe
- req_ready  out  1  high in IDLE only
- req_rd  in  1  1 = read, 0 = write
- req_sa  in  7  7-bit slave address
- req_ra  in  8  register (inner) address
- req_len  in  LEN_W  data byte count
- wd_data  in  8  write data byte
- wd_valid  in  1  write data available
- wd_ready  out  1  write byte consumed this cycle
- rd_data  out  8  read byte
- rd_valid  out  1  one-cycle strobe per read byte; no backpressure
- done  out  1  one-cycle completion pulse
- nak  out  1  status, valid with done: some master-transmitted byte was NAKed
- tmo  out  1  status, valid with done: timeout abort (0 if IIC_TIMEOUT_EN undefined)
- cmd_din  out  10  command word to command FIFO
- cmd_write  out  1  command FIFO write
- cmd_full  in  1  command FIFO full
- rsp_din  in  9  result word; [8:1] = byte on bus, [0] = ack bit sampled (0 = ACK)
- rsp_valid  in  1  result word strobe (master's data-FIFO write)

Behaviour:
- Reset (async): state IDLE. req_ready=1. cmd_write=0, cmd_din=0. wd_ready=0. rd_valid=0, rd_data=0. done=0, nak=0, tmo=0. Counters cleared.
- Command encoding:
  - START = 10'b1_0000_0000_0; STOP = 10'b1_1000_0000_0.
  - Transmit byte b = {1'b0, b, 1'b1}.
  - Read byte with ACK = {1'b0, 8'hFF, 1'b0}; read byte with NAK = {1'b0, 8'hFF, 1'b1}.
- Accept: req_valid && req_ready latches all req_* fields. A read with req_len=0 is executed as len 1.
- FSM states: IDLE, ST, SAW, RA, WD, RST, SAR, RDB, SP, WAIT, FIN.
  - Write path: IDLE → ST → SAW → RA → WD (len times; skipped if len=0) → SP → WAIT → FIN → IDLE.
  - Read path: IDLE → ST → SAW → RA → RST → SAR → RDB (len times; last byte NAK, others ACK) → SP → WAIT → FIN → IDLE.
- Issue rule: each issuing state drives cmd_write=1 for exactly one cycle when cmd_full=0, then advances. When cmd_full=1 it holds with cmd_write=0. Maximum rate is one word per cycle.
- WD: issues only when wd_valid && !cmd_full. wd_ready pulses in that same cycle and the byte goes into cmd_din.
- Result tracking runs in parallel with issuing:
  - Expected results = 2+len (write) or 3+len (read); rsp_idx counts from 0.
  - Transmit results (write: all idx; read: idx 0, 1, 2) with rsp_din[0]=1 set a sticky nak_acc.
  - Read data results (idx ≥ 3): rd_valid=1 for one cycle, rd_data=rsp_din[8:1], one cycle after rsp_valid.
  - A rsp_valid arriving in IDLE is ignored.
- WAIT exits when rsp_idx reaches the expected count, including when the last result and the stop issue land in the same cycle.
- FIN: done=1 for one cycle; nak=nak_acc and tmo are held until the next accept; req_ready returns the next cycle.
- A NAK does not abort: the stop is still issued and all results are drained. Read bytes after an address NAK are still delivered (0xFF from bus pull-up).
- No request is accepted while busy. Reset mid-transaction returns to IDLE immediately; the FIFOs and master must be reset by the same rst.

Optional Feature:
- IIC_TIMEOUT_EN defined: a watchdog counts cycles in any non-IDLE state. It clears on each rsp_valid and on each cmd_write. Reaching TIMEOUT jumps to FIN with tmo=1 and abandons remaining results.
- IIC_TIMEOUT_EN undefined: no counter, tmo tied to 0, and a stuck bus hangs in WAIT.

Decomposition:
- Package iic_pkg:
  - Localparams IIC_CMD_START, IIC_CMD_STOP.
  - Functions iic_cmd_tx(byte) and iic_cmd_rx(nak).
  - typedef enum state_e.
  - typedef struct for the latched request.
- One natural sub-module, iic_rsp_tracker: result counter, nak accumulation, read data strobe; reports rsp_all_done.

Test Plan:
- Write to absent slave: sa=0x5b, ra=0x39, len=1, wd=0x39 → commands START, {0,0xB6,1}, {0,0x39,1}, {0,0x39,1}, STOP; done with nak=1, tmo=0.
- Write burst: sa=0x5a, ra=0x39, len=2, wd=0xC9,0x65 → done nak=0; slave RAM[0x39]=0xC9, RAM[0x3A]=0x65; exactly 2 wd_ready pulses.
- Read back: sa=0x5a, ra=0x39, rd, len=3 → rd_valid ×3 with 0xC9, 0x65, 0x00; last read command word = 10'b0_1111_1111_1; done nak=0.
- Backpressure: hold cmd_full=1 for 50 cycles mid-request, and deassert wd_valid for 20 cycles → no lost or duplicated command words; same RAM result.
- Reset mid-read (rst pulsed after the 4th command word) → all outputs at reset values; the next write request completes with nak=0.
- With IIC_TIMEOUT_EN, TIMEOUT=1000, SCL held low externally → done with tmo=1 after 1000 cycles of no progress; without the macro, still busy at 5000 cycles.
